// File: rtl/gshare_predictor.sv
// gshare branch direction predictor for the LC-3b pipeline.
// The IF-stage lookup XORs fetch-address bits with a global history register
// to index a table of 2-bit saturating counters. Training happens only when a
// branch resolves in WB, using the index that travelled down the pipe with it.
// Three saturating performance counters track correct predictions,
// mispredictions and stall cycles.
module gshare_predictor #(
    parameter int unsigned IDX_BITS   = 5,
    parameter int unsigned HIST_BITS  = 4,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          mem_address_IF,
    input  logic                 br_instruction_IF,
    output logic                 prediction,
    output logic [IDX_BITS-1:0]  pred_index_IF,
    input  logic                 update_valid,
    input  logic [IDX_BITS-1:0]  update_index,
    input  logic                 taken_WB,
    input  logic                 prediction_WB,
    input  logic                 stall_in,
    input  logic                 cnt_clear,
    output logic                 mispredict,
    output logic [CNT_WIDTH-1:0] bpredict_count,
    output logic [CNT_WIDTH-1:0] bmispredict_count,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int unsigned DEPTH = 1 << IDX_BITS;

    // Address bits that feed the index; bit 0 is always excluded because
    // instructions are word aligned.
    localparam logic [15:0] ADDR_USED = 16'(((32'd1 << IDX_BITS) - 32'd1) << 1);

    logic [1:0]           pht_q [DEPTH];
    logic [1:0]           pht_upd_d;
    logic [IDX_BITS-1:0]  hist_idx;

    logic [CNT_WIDTH-1:0] bp_q, bp_d;
    logic [CNT_WIDTH-1:0] bm_q, bm_d;
    logic [CNT_WIDTH-1:0] st_q, st_d;

    logic                 unused_addr_bits;

    assign unused_addr_bits = ^(mem_address_IF & ~ADDR_USED);

    // Global history: exists only when HIST_BITS > 0, otherwise the index is
    // built from address bits alone (bimodal mode).
    generate
        if (HIST_BITS > 0) begin : g_ghr
            logic [HIST_BITS-1:0] ghr_q, ghr_d;
            logic [HIST_BITS:0]   ghr_shift;

            // Next history: shift in the resolved direction, drop the oldest bit.
            always_comb begin
                ghr_shift = {ghr_q, taken_WB};
                ghr_d     = ghr_q;
                if (update_valid) begin
                    ghr_d = ghr_shift[HIST_BITS-1:0];
                end
            end

            // History register, updated non-speculatively at resolution.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ghr_q <= '0;
                end else begin
                    ghr_q <= ghr_d;
                end
            end

            assign hist_idx = IDX_BITS'(ghr_q);
        end else begin : g_no_ghr
            assign hist_idx = '0;
        end
    endgenerate

    assign pred_index_IF = mem_address_IF[IDX_BITS:1] ^ hist_idx;

    // Combinational table read; a same-cycle update is not forwarded, so the
    // prediction reflects the pre-update counter.
    assign prediction = br_instruction_IF & pht_q[pred_index_IF][1];

    assign mispredict = update_valid & (taken_WB ^ prediction_WB);

    // Saturating 2-bit counter step for the resolving branch's entry.
    always_comb begin
        pht_upd_d = pht_q[update_index];
        if (taken_WB) begin
            if (pht_upd_d != 2'd3) begin
                pht_upd_d = pht_upd_d + 2'd1;
            end
        end else begin
            if (pht_upd_d != 2'd0) begin
                pht_upd_d = pht_upd_d - 2'd1;
            end
        end
    end

    // Pattern history table: write only the resolving entry; stall never blocks it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pht_q <= '{default: INIT_STATE};
        end else if (update_valid) begin
            pht_q[update_index] <= pht_upd_d;
        end
    end

    // Clear wins over increment; counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_next(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 inc,
        input logic                 clr
    );
        if (clr) begin
            return '0;
        end
        if (inc && (cnt != '1)) begin
            return cnt + CNT_WIDTH'(1);
        end
        return cnt;
    endfunction

    // Next values of the three performance counters.
    always_comb begin
        bp_d = sat_next(bp_q, update_valid & ~mispredict, cnt_clear);
        bm_d = sat_next(bm_q, mispredict, cnt_clear);
        st_d = sat_next(st_q, stall_in, cnt_clear);
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_q <= '0;
            bm_q <= '0;
            st_q <= '0;
        end else begin
            bp_q <= bp_d;
            bm_q <= bm_d;
            st_q <= st_d;
        end
    end

    assign bpredict_count    = bp_q;
    assign bmispredict_count = bm_q;
    assign stall_count       = st_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: a directed vector table on the
// default configuration, hand sequences on a 2-bit-counter instance and a
// bimodal instance, then randomized traffic against a behavioural model.
module tb_gshare_predictor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Instance A: default parameters
    logic [15:0] a_addr;
    logic        a_br, a_uv, a_taken, a_pwb, a_stall, a_clr;
    logic [4:0]  a_uidx, a_idx;
    logic        a_pred, a_misp;
    logic [15:0] a_bp, a_bm, a_sc;

    // Instance B: CNT_WIDTH = 2
    logic [15:0] b_addr;
    logic        b_br, b_uv, b_taken, b_pwb, b_stall, b_clr;
    logic [4:0]  b_uidx, b_idx;
    logic        b_pred, b_misp;
    logic [1:0]  b_bp, b_bm, b_sc;

    // Instance C: bimodal, IDX_BITS = 3
    logic [15:0] c_addr;
    logic        c_br, c_uv, c_taken, c_pwb, c_stall, c_clr;
    logic [2:0]  c_uidx, c_idx;
    logic        c_pred, c_misp;
    logic [15:0] c_bp, c_bm, c_sc;

    gshare_predictor u_a (
        .clk(clk), .rst_n(rst_n),
        .mem_address_IF(a_addr), .br_instruction_IF(a_br),
        .prediction(a_pred), .pred_index_IF(a_idx),
        .update_valid(a_uv), .update_index(a_uidx),
        .taken_WB(a_taken), .prediction_WB(a_pwb),
        .stall_in(a_stall), .cnt_clear(a_clr), .mispredict(a_misp),
        .bpredict_count(a_bp), .bmispredict_count(a_bm), .stall_count(a_sc)
    );

    gshare_predictor #(.CNT_WIDTH(2)) u_b (
        .clk(clk), .rst_n(rst_n),
        .mem_address_IF(b_addr), .br_instruction_IF(b_br),
        .prediction(b_pred), .pred_index_IF(b_idx),
        .update_valid(b_uv), .update_index(b_uidx),
        .taken_WB(b_taken), .prediction_WB(b_pwb),
        .stall_in(b_stall), .cnt_clear(b_clr), .mispredict(b_misp),
        .bpredict_count(b_bp), .bmispredict_count(b_bm), .stall_count(b_sc)
    );

    gshare_predictor #(.IDX_BITS(3), .HIST_BITS(0)) u_c (
        .clk(clk), .rst_n(rst_n),
        .mem_address_IF(c_addr), .br_instruction_IF(c_br),
        .prediction(c_pred), .pred_index_IF(c_idx),
        .update_valid(c_uv), .update_index(c_uidx),
        .taken_WB(c_taken), .prediction_WB(c_pwb),
        .stall_in(c_stall), .cnt_clear(c_clr), .mispredict(c_misp),
        .bpredict_count(c_bp), .bmispredict_count(c_bm), .stall_count(c_sc)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model of instance A
    int m_pht [32];
    int m_ghr, m_bp, m_bm, m_sc;

    function automatic void m_reset();
        foreach (m_pht[i]) m_pht[i] = 1;
        m_ghr = 0;
        m_bp  = 0;
        m_bm  = 0;
        m_sc  = 0;
    endfunction

    function automatic int m_index(input int addr);
        return ((addr >> 1) % 32) ^ m_ghr;
    endfunction

    function automatic void m_clock(input int uv, uidx, taken, pwb, stall, clr);
        int lim;
        lim = 65535;
        if (clr != 0) begin
            m_bp = 0;
            m_bm = 0;
            m_sc = 0;
        end else begin
            if (uv != 0 && taken == pwb && m_bp < lim) m_bp++;
            if (uv != 0 && taken != pwb && m_bm < lim) m_bm++;
            if (stall != 0 && m_sc < lim) m_sc++;
        end
        if (uv != 0) begin
            if (taken != 0) m_pht[uidx] = (m_pht[uidx] < 3) ? m_pht[uidx] + 1 : 3;
            else            m_pht[uidx] = (m_pht[uidx] > 0) ? m_pht[uidx] - 1 : 0;
            m_ghr = (m_ghr * 2 + (taken != 0 ? 1 : 0)) % 16;
        end
    endfunction

    task automatic a_drive(input int addr, br, uv, uidx, taken, pwb, stall, clr);
        a_addr  = 16'(addr);
        a_br    = 1'(br);
        a_uv    = 1'(uv);
        a_uidx  = 5'(uidx);
        a_taken = 1'(taken);
        a_pwb   = 1'(pwb);
        a_stall = 1'(stall);
        a_clr   = 1'(clr);
    endtask

    // One cycle on instance A, checked against the model.
    task automatic a_step(input int addr, br, uv, uidx, taken, pwb, stall, clr);
        int eidx;
        @(negedge clk);
        a_drive(addr, br, uv, uidx, taken, pwb, stall, clr);
        #1;
        eidx = m_index(addr);
        chk("rnd_idx",  32'(a_idx),  32'(eidx));
        chk("rnd_pred", 32'(a_pred), 32'(br != 0 && m_pht[eidx] >= 2));
        chk("rnd_misp", 32'(a_misp), 32'(uv != 0 && taken != pwb));
        @(posedge clk);
        m_clock(uv, uidx, taken, pwb, stall, clr);
        #1;
        chk("rnd_bp", 32'(a_bp), 32'(m_bp));
        chk("rnd_bm", 32'(a_bm), 32'(m_bm));
        chk("rnd_sc", 32'(a_sc), 32'(m_sc));
    endtask

    // Async reset pulse between clock edges with instance A idle.
    task automatic reset_pulse();
        @(negedge clk);
        a_drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        chk("rstp_bp", 32'(a_bp), 32'd0);
        chk("rstp_bm", 32'(a_bm), 32'd0);
        chk("rstp_sc", 32'(a_sc), 32'd0);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [15:0] addr;
        int br, uv, uidx, taken, pwb, stall, clr;
        int e_idx, e_pred, e_misp, e_bp, e_bm, e_sc;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // addr, br,uv,uidx,taken,pwb,stall,clr, idx,pred,misp, bp,bm,sc (counters after the edge)
        tbl[0]  = '{16'h0010, 1,0,0,0,0,0,0, 8'h08,0,0, 0,0,0};
        tbl[1]  = '{16'h0010, 1,1,8,1,0,0,0, 8'h08,0,1, 0,1,0};
        tbl[2]  = '{16'h0010, 1,1,8,1,0,0,0, 8'h09,0,1, 0,2,0};
        tbl[3]  = '{16'h0010, 1,0,0,0,0,0,0, 8'h0B,0,0, 0,2,0};
        tbl[4]  = '{16'h0016, 1,0,0,0,0,0,0, 8'h08,1,0, 0,2,0};
        tbl[5]  = '{16'h0016, 0,0,0,0,0,0,0, 8'h08,0,0, 0,2,0};
        tbl[6]  = '{16'h0016, 1,1,8,0,1,0,0, 8'h08,1,1, 0,3,0};
        tbl[7]  = '{16'h001C, 1,1,8,0,0,0,0, 8'h08,1,0, 1,3,0};
        tbl[8]  = '{16'h0009, 1,0,0,0,0,0,0, 8'h08,0,0, 1,3,0};
        tbl[9]  = '{16'h0009, 1,1,8,1,0,1,0, 8'h08,0,1, 1,4,1};
        tbl[10] = '{16'h0002, 1,0,0,0,0,1,1, 8'h08,1,0, 0,0,0};
        tbl[11] = '{16'h0002, 1,1,8,1,1,1,0, 8'h08,1,0, 1,0,1};
        tbl[12] = '{16'h0016, 1,0,0,0,0,0,0, 8'h08,1,0, 1,0,1};

        a_drive(16'h0010, 1, 1, 8, 1, 0, 0, 0);
        b_addr = '0; b_br = 1'b0; b_uv = 1'b0; b_uidx = '0; b_taken = 1'b0;
        b_pwb = 1'b0; b_stall = 1'b0; b_clr = 1'b0;
        c_addr = '0; c_br = 1'b0; c_uv = 1'b0; c_uidx = '0; c_taken = 1'b0;
        c_pwb = 1'b0; c_stall = 1'b0; c_clr = 1'b0;
        m_reset();

        // Behaviour while reset is held, including across a clock edge
        #2;
        chk("rst_idx",  32'(a_idx),  32'h08);
        chk("rst_pred", 32'(a_pred), 32'd0);
        chk("rst_misp", 32'(a_misp), 32'd1);
        @(posedge clk); #1;
        chk("rst_bm_hold", 32'(a_bm), 32'd0);
        chk("rst_bp_hold", 32'(a_bp), 32'd0);
        @(negedge clk);
        a_drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Directed vector table on instance A
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            a_drive(int'(tbl[i].addr), tbl[i].br, tbl[i].uv, tbl[i].uidx,
                    tbl[i].taken, tbl[i].pwb, tbl[i].stall, tbl[i].clr);
            #1;
            chk("tbl_idx",  32'(a_idx),  32'(tbl[i].e_idx));
            chk("tbl_pred", 32'(a_pred), 32'(tbl[i].e_pred));
            chk("tbl_misp", 32'(a_misp), 32'(tbl[i].e_misp));
            @(posedge clk); #1;
            chk("tbl_bp", 32'(a_bp), 32'(tbl[i].e_bp));
            chk("tbl_bm", 32'(a_bm), 32'(tbl[i].e_bm));
            chk("tbl_sc", 32'(a_sc), 32'(tbl[i].e_sc));
        end
        @(negedge clk);
        a_drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Instance B: 2-bit counters saturate, clear beats a same-edge increment
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b_uv = 1'b1; b_taken = 1'b1; b_pwb = 1'b1; b_uidx = 5'(i);
            @(posedge clk); #1;
            chk("b_bp_sat", 32'(b_bp), 32'((i + 1 < 3) ? i + 1 : 3));
        end
        @(negedge clk);
        b_clr = 1'b1;
        #1;
        chk("b_idx",  32'(b_idx),  32'h0F);
        chk("b_pred", 32'(b_pred), 32'd0);
        chk("b_misp", 32'(b_misp), 32'd0);
        @(posedge clk); #1;
        chk("b_bp_clr", 32'(b_bp), 32'd0);
        chk("b_bm_clr", 32'(b_bm), 32'd0);
        chk("b_sc_clr", 32'(b_sc), 32'd0);
        @(negedge clk);
        b_clr = 1'b0; b_uv = 1'b0;

        // Instance C: bimodal indexing, stall counting, async reset between edges
        @(negedge clk);
        c_addr = 16'hFFFA; c_br = 1'b1;
        #1;
        chk("c_idx0",  32'(c_idx),  32'd5);
        chk("c_pred0", 32'(c_pred), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            c_stall = 1'b1;
            c_uv = (i < 2); c_uidx = 3'd5; c_taken = 1'b1; c_pwb = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        c_stall = 1'b0; c_uv = 1'b0;
        #1;
        chk("c_idx_nohist", 32'(c_idx),  32'd5);
        chk("c_pred_tr",    32'(c_pred), 32'd1);
        chk("c_sc4",        32'(c_sc),   32'd4);
        chk("c_bp2",        32'(c_bp),   32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("c_rst_sc",   32'(c_sc),   32'd0);
        chk("c_rst_bp",   32'(c_bp),   32'd0);
        chk("c_rst_bm",   32'(c_bm),   32'd0);
        chk("c_rst_pred", 32'(c_pred), 32'd0);
        c_uv = 1'b1; c_uidx = 3'd5; c_taken = 1'b0; c_pwb = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("c_fresh_bp",   32'(c_bp),   32'd1);
        chk("c_fresh_misp", 32'(c_misp), 32'd0);
        @(negedge clk);
        c_uv = 1'b0;
        #1;
        chk("c_fresh_pred", 32'(c_pred), 32'd0);

        // Randomized traffic on instance A against the model
        reset_pulse();
        for (int n = 0; n < 400; n++) begin
            int addr, br, uv, uidx, taken, pwb, stall, clr;
            if (n == 200) reset_pulse();
            addr  = int'($urandom_range(0, 65535));
            br    = int'($urandom_range(0, 1));
            uv    = ($urandom_range(0, 3) != 0) ? 1 : 0;
            uidx  = ($urandom_range(0, 2) == 0) ? m_index(addr) : int'($urandom_range(0, 31));
            taken = int'($urandom_range(0, 1));
            pwb   = int'($urandom_range(0, 1));
            stall = int'($urandom_range(0, 1));
            clr   = ($urandom_range(0, 49) == 0) ? 1 : 0;
            a_step(addr, br, uv, uidx, taken, pwb, stall, clr);
        end

        // Counter saturation on one entry: 5 taken, 4 not-taken, 1 taken, read
        reset_pulse();
        for (int k = 0; k < 10; k++) begin
            a_step((3 ^ m_ghr) << 1, 1, 1, 3, (k < 5 || k == 9) ? 1 : 0, 1, 0, 0);
        end
        a_step((3 ^ m_ghr) << 1, 1, 0, 0, 0, 0, 0, 0);
        chk("sat_floor_pred", 32'(a_pred), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
